inst_fetch_buf: RTL

Instruction fetch buffer between the CPU core's instruction-ROM port (`rom_ce_o`/`rom_addr_o`/`rom_data_i`) and a slower request/acknowledge instruction memory.
- Holds a small direct-mapped, one-word-per-entry instruction store.
- Hits return the word combinationally in the same cycle.
- Misses raise `stallreq_o`, run one memory handshake, fill the entry, then hit.
- Sits directly upstream of the core's IF/ID register.

---
 rtl/inst_fetch_buf_pkg.sv | 17 +
 rtl/inst_buf_array.sv | 49 ++++
 rtl/inst_fetch_buf.sv | 109 ++++++++++
 3 files changed

// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Fill FSM encoding, miss-counter width and its saturating increment.
package inst_fetch_buf_pkg;

    typedef enum logic [0:0] {
        IfbIdle = 1'b0,
        IfbWait = 1'b1
    } ifb_state_e;

    localparam int unsigned MissCntW = 16;
    localparam logic [MissCntW-1:0] MissCntMax = '1;

    function automatic logic [MissCntW-1:0] sat_inc(input logic [MissCntW-1:0] val);
        return (val == MissCntMax) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/inst_buf_array.sv
// Valid/tag/data storage for the direct-mapped fetch buffer.
// Combinational read port, one synchronous write port, synchronous clear-all.
module inst_buf_array #(
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned TAG_W  = 28,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned Entries = 1 << IDX_W;

    logic [Entries-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [Entries];
    logic [DATA_W-1:0]  data_q [Entries];

    // Clear takes priority so a flush on the fill edge leaves the entry invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[waddr_i]  <= wtag_i;
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_valid_o = valid_q[raddr_i];
    assign rd_tag_o   = tag_q[raddr_i];
    assign rd_data_o  = data_q[raddr_i];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: same-cycle hits, one req/ack memory fill per miss.
// Holds the fill FSM, drop flag, request registers and miss counter.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rom_ce_i,
    input  logic [ADDR_W-1:0]   rom_addr_i,
    output logic [DATA_W-1:0]   rom_data_o,
    output logic                stallreq_o,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic [MissCntW-1:0] miss_cnt_o
);

    localparam int unsigned TagW = ADDR_W - IDX_W - 2;

    ifb_state_e          state_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic                mem_req_q;
    logic                drop_q;
    logic [MissCntW-1:0] miss_cnt_q;

    logic [IDX_W-1:0]  lk_idx;
    logic [TagW-1:0]   lk_tag;
    logic              rd_valid;
    logic [TagW-1:0]   rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              miss;
    logic              fill_we;
    logic              unused_addr_lsb;

    assign lk_idx = rom_addr_i[IDX_W+1:2];
    assign lk_tag = rom_addr_i[ADDR_W-1:IDX_W+2];
    // Byte offset within the word plays no part in the lookup.
    assign unused_addr_lsb = ^rom_addr_i[1:0];

    assign hit  = rom_ce_i & rd_valid & (rd_tag == lk_tag);
    assign miss = rom_ce_i & ~hit;

    assign rom_data_o = hit ? rd_data : '0;
    assign stallreq_o = miss;

    // A flush in flight or on the ack edge discards the returning word.
    assign fill_we = (state_q == IfbWait) & mem_ack_i & ~drop_q & ~flush_i;

    inst_buf_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TagW),
        .DATA_W (DATA_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (flush_i),
        .we_i       (fill_we),
        .waddr_i    (req_addr_q[IDX_W+1:2]),
        .wtag_i     (req_addr_q[ADDR_W-1:IDX_W+2]),
        .wdata_i    (mem_rdata_i),
        .raddr_i    (lk_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IfbIdle;
            req_addr_q <= '0;
            mem_req_q  <= 1'b0;
            drop_q     <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                IfbIdle: begin
                    if (miss) begin
                        state_q    <= IfbWait;
                        req_addr_q <= {rom_addr_i[ADDR_W-1:2], 2'b00};
                        mem_req_q  <= 1'b1;
                        miss_cnt_q <= sat_inc(miss_cnt_q);
                    end
                end
                IfbWait: begin
                    if (mem_ack_i) begin
                        state_q   <= IfbIdle;
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IfbIdle;
            endcase
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = req_addr_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule
